fir_mac_sequencer: RTL and testbench

Control sequencer for a time-multiplexed FIR filter that shares one multiplier and one accumulator across all taps. On each input sample strobe it writes the new sample into a circular delay-line RAM, then issues one (sample, coefficient) read pair per tap. It also generates the accumulator clear/enable strobes, aligned to the multiplier pipeline latency, and flags the completed output sample. It sits between the sample-rate enable and the shared MAC datapath; it contains no arithmetic on sample data.

---
 rtl/fir_mac_sequencer.sv | 169 ++++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: control sequencer for a time-multiplexed FIR filter.
// On each accepted sample strobe it writes the new sample into the circular
// delay line, then issues one (sample, coefficient) read pair per tap, newest
// sample first. Accumulator clear/enable strobes follow the read pairs after
// MULT_LAT cycles, and out_valid marks the finished output sample.
// All outputs come straight from flops; no arithmetic touches sample data.
module fir_mac_sequencer #(
  parameter int NUM_TAPS = 16,
  parameter int MULT_LAT = 2,
  localparam int ADDR_W = $clog2(NUM_TAPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sam_clk_en,
  output logic              busy,
  output logic              dl_wr_en,
  output logic [ADDR_W-1:0] dl_wr_addr,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] dl_rd_addr,
  output logic [ADDR_W-1:0] coef_addr,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              out_valid,
  output logic              overrun
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_MAC   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_TAPS - 1);
  localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1'b1);

  // Pipeline pattern in which only the final read's product is still in
  // flight and is being presented to the accumulator this cycle.
  localparam logic [MULT_LAT-1:0] PIPE_LAST = MULT_LAT'(1'b1) << (MULT_LAT - 1);

  logic [2:0]          state_r, state_s;
  logic [ADDR_W-1:0]   wr_ptr_r, wr_ptr_s;
  logic [ADDR_W-1:0]   base_r, base_s;
  logic                busy_r, busy_s;
  logic                dl_wr_en_r, dl_wr_en_s;
  logic [ADDR_W-1:0]   dl_wr_addr_r, dl_wr_addr_s;
  logic                rd_valid_r, rd_valid_s;
  logic [ADDR_W-1:0]   dl_rd_addr_r, dl_rd_addr_s;
  logic [ADDR_W-1:0]   coef_addr_r, coef_addr_s;
  logic [MULT_LAT-1:0] acc_pipe_r, acc_pipe_s;
  logic [MULT_LAT-1:0] clr_pipe_r, clr_pipe_s;
  logic                out_valid_r, out_valid_s;
  logic                overrun_r, overrun_s;

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so that every port is driven directly by a flop.
  always_comb begin
    state_s      = state_r;
    wr_ptr_s     = wr_ptr_r;
    base_s       = base_r;
    busy_s       = busy_r;
    dl_wr_en_s   = 1'b0;
    dl_wr_addr_s = ZERO_ADDR;
    rd_valid_s   = 1'b0;
    dl_rd_addr_s = ZERO_ADDR;
    coef_addr_s  = ZERO_ADDR;
    out_valid_s  = 1'b0;
    // A strobe outside IDLE is dropped but remembered until reset.
    overrun_s    = overrun_r | (sam_clk_en & (state_r != ST_IDLE));
    // The k=0 read carries the clear so the accumulator loads instead of adds.
    acc_pipe_s   = (acc_pipe_r << 1) | MULT_LAT'(rd_valid_r);
    clr_pipe_s   = (clr_pipe_r << 1) | MULT_LAT'(rd_valid_r & (coef_addr_r == ZERO_ADDR));

    case (state_r)
      ST_IDLE: begin
        if (sam_clk_en) begin
          state_s      = ST_LOAD;
          busy_s       = 1'b1;
          dl_wr_en_s   = 1'b1;
          dl_wr_addr_s = wr_ptr_r;
          base_s       = wr_ptr_r;
          wr_ptr_s     = (wr_ptr_r == LAST_ADDR) ? ZERO_ADDR : (wr_ptr_r + ONE_ADDR);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // First read pair: the sample just written, coefficient 0.
        state_s      = ST_MAC;
        rd_valid_s   = 1'b1;
        coef_addr_s  = ZERO_ADDR;
        dl_rd_addr_s = base_r;
      end
      ST_MAC: begin
        if (coef_addr_r == LAST_ADDR) begin
          state_s = ST_DRAIN;
        end else begin
          // Step back through the delay line toward older samples; the
          // wrap uses an explicit compare since NUM_TAPS need not be 2^n.
          rd_valid_s   = 1'b1;
          coef_addr_s  = coef_addr_r + ONE_ADDR;
          dl_rd_addr_s = (dl_rd_addr_r == ZERO_ADDR) ? LAST_ADDR : (dl_rd_addr_r - ONE_ADDR);
        end
      end
      ST_DRAIN: begin
        if (acc_pipe_r == PIPE_LAST) begin
          state_s     = ST_DONE;
          out_valid_s = 1'b1;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any sample in progress and
  // flushes the latency pipeline so no stale acc_en/out_valid escapes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      wr_ptr_r     <= ZERO_ADDR;
      base_r       <= ZERO_ADDR;
      busy_r       <= 1'b0;
      dl_wr_en_r   <= 1'b0;
      dl_wr_addr_r <= ZERO_ADDR;
      rd_valid_r   <= 1'b0;
      dl_rd_addr_r <= ZERO_ADDR;
      coef_addr_r  <= ZERO_ADDR;
      acc_pipe_r   <= {MULT_LAT{1'b0}};
      clr_pipe_r   <= {MULT_LAT{1'b0}};
      out_valid_r  <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      wr_ptr_r     <= wr_ptr_s;
      base_r       <= base_s;
      busy_r       <= busy_s;
      dl_wr_en_r   <= dl_wr_en_s;
      dl_wr_addr_r <= dl_wr_addr_s;
      rd_valid_r   <= rd_valid_s;
      dl_rd_addr_r <= dl_rd_addr_s;
      coef_addr_r  <= coef_addr_s;
      acc_pipe_r   <= acc_pipe_s;
      clr_pipe_r   <= clr_pipe_s;
      out_valid_r  <= out_valid_s;
      overrun_r    <= overrun_s;
    end
  end

  assign busy       = busy_r;
  assign dl_wr_en   = dl_wr_en_r;
  assign dl_wr_addr = dl_wr_addr_r;
  assign rd_valid   = rd_valid_r;
  assign dl_rd_addr = dl_rd_addr_r;
  assign coef_addr  = coef_addr_r;
  assign acc_en     = acc_pipe_r[MULT_LAT-1];
  assign acc_clr    = clr_pipe_r[MULT_LAT-1];
  assign out_valid  = out_valid_r;
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: two instances (4 taps / latency 2 and
// 5 taps / latency 3) share one stimulus stream. A cycle-indexed timetable
// model predicts every output of both instances; directed checks pin the
// hand-computed values.
module tb_fir_mac_sequencer;

  localparam int CYC = 2048;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sam_clk_en = 1'b0;

  logic       busy0, wr_en0, rv0, clr0, en0, ovf0, ovr0;
  logic [1:0] wa0, ra0, ca0;
  logic       busy1, wr_en1, rv1, clr1, en1, ovf1, ovr1;
  logic [2:0] wa1, ra1, ca1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model timetable: expected value of each output per cycle, per instance.
  int nt[2] = '{4, 5};
  int ml[2] = '{2, 3};
  bit e_busy[2][CYC];
  bit e_wr[2][CYC];
  bit e_rv[2][CYC];
  bit e_clr[2][CYC];
  bit e_en[2][CYC];
  bit e_ovf[2][CYC];
  bit e_ov[2][CYC];
  int e_wa[2][CYC];
  int e_ra[2][CYC];
  int e_ca[2][CYC];
  int m_wp[2] = '{0, 0};
  int m_bend[2] = '{-1, -1};
  bit m_ovr[2] = '{1'b0, 1'b0};

  fir_mac_sequencer #(.NUM_TAPS(4), .MULT_LAT(2)) dut0 (
    .clk(clk), .reset(reset), .sam_clk_en(sam_clk_en),
    .busy(busy0), .dl_wr_en(wr_en0), .dl_wr_addr(wa0),
    .rd_valid(rv0), .dl_rd_addr(ra0), .coef_addr(ca0),
    .acc_clr(clr0), .acc_en(en0), .out_valid(ovf0), .overrun(ovr0)
  );

  fir_mac_sequencer #(.NUM_TAPS(5), .MULT_LAT(3)) dut1 (
    .clk(clk), .reset(reset), .sam_clk_en(sam_clk_en),
    .busy(busy1), .dl_wr_en(wr_en1), .dl_wr_addr(wa1),
    .rd_valid(rv1), .dl_rd_addr(ra1), .coef_addr(ca1),
    .acc_clr(clr1), .acc_en(en1), .out_valid(ovf1), .overrun(ovr1)
  );

  initial forever #5 clk = ~clk;

  // Model: at each edge e, a strobe or reset decides outputs of cycles e+1...
  initial begin
    forever begin
      int e;
      @(posedge clk);
      e = cyc;
      for (int d = 0; d < 2; d++) begin
        if (reset) begin
          for (int j = e + 1; j < e + 64 && j < CYC; j++) begin
            e_busy[d][j] = 1'b0; e_wr[d][j] = 1'b0; e_rv[d][j] = 1'b0;
            e_clr[d][j] = 1'b0; e_en[d][j] = 1'b0; e_ovf[d][j] = 1'b0;
            e_wa[d][j] = 0; e_ra[d][j] = 0; e_ca[d][j] = 0;
          end
          m_wp[d] = 0;
          m_bend[d] = e;
          m_ovr[d] = 1'b0;
        end else if (sam_clk_en) begin
          if (e > m_bend[d] && e + 40 < CYC) begin
            int n;
            int l;
            n = nt[d];
            l = ml[d];
            e_wr[d][e + 1] = 1'b1;
            e_wa[d][e + 1] = m_wp[d];
            for (int k = 0; k < n; k++) begin
              e_rv[d][e + 2 + k] = 1'b1;
              e_ra[d][e + 2 + k] = (m_wp[d] - k + n) % n;
              e_ca[d][e + 2 + k] = k;
              e_en[d][e + 2 + k + l] = 1'b1;
            end
            e_clr[d][e + 2 + l] = 1'b1;
            e_ovf[d][e + 2 + l + n] = 1'b1;
            for (int j = e + 1; j <= e + 2 + l + n; j++) e_busy[d][j] = 1'b1;
            m_bend[d] = e + 2 + l + n;
            m_wp[d] = (m_wp[d] + 1) % n;
          end else begin
            m_ovr[d] = 1'b1;
          end
        end
        if (e + 1 < CYC) e_ov[d][e + 1] = m_ovr[d];
      end
      cyc = cyc + 1;
    end
  end

  function automatic logic [18:0] pack(input logic b, input logic w, input logic [3:0] wa,
                                       input logic rv, input logic [3:0] ra, input logic [3:0] ca,
                                       input logic cl, input logic en, input logic ovf, input logic ov);
    return {b, w, wa, rv, ra, ca, cl, en, ovf, ov};
  endfunction

  // Compare process: every cycle, both instances against the model.
  initial begin
    forever begin
      logic [18:0] act;
      logic [18:0] exp;
      @(negedge clk);
      if (cyc >= 1 && cyc < CYC) begin
        act = pack(busy0, wr_en0, {2'b00, wa0}, rv0, {2'b00, ra0}, {2'b00, ca0}, clr0, en0, ovf0, ovr0);
        exp = pack(e_busy[0][cyc], e_wr[0][cyc], 4'(e_wa[0][cyc]), e_rv[0][cyc], 4'(e_ra[0][cyc]),
                   4'(e_ca[0][cyc]), e_clr[0][cyc], e_en[0][cyc], e_ovf[0][cyc], e_ov[0][cyc]);
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL model_dut0 cycle=%0d actual=%h expected=%h", cyc, act, exp);
        end
        act = pack(busy1, wr_en1, {1'b0, wa1}, rv1, {1'b0, ra1}, {1'b0, ca1}, clr1, en1, ovf1, ovr1);
        exp = pack(e_busy[1][cyc], e_wr[1][cyc], 4'(e_wa[1][cyc]), e_rv[1][cyc], 4'(e_ra[1][cyc]),
                   4'(e_ca[1][cyc]), e_clr[1][cyc], e_en[1][cyc], e_ovf[1][cyc], e_ov[1][cyc]);
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL model_dut1 cycle=%0d actual=%h expected=%h", cyc, act, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle t0+1 of the strobe.
  task automatic strobe();
    sam_clk_en = 1'b1;
    tick();
    sam_clk_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  int ra4[4] = '{0, 3, 2, 1};
  int ra4b[4] = '{1, 0, 3, 2};
  int ra5[5] = '{0, 4, 3, 2, 1};
  int wb[5] = '{0, 1, 2, 3, 0};

  // Directed stimulus with hand-computed expectations.
  initial begin
    // Reset state.
    tick();
    tick();
    tick();
    check("reset_outputs0", {busy0, wr_en0, wa0, rv0, ra0, ca0, clr0, en0, ovf0, ovr0}, 0);
    check("reset_outputs1", {busy1, wr_en1, wa1, rv1, ra1, ca1, clr1, en1, ovf1, ovr1}, 0);
    reset = 1'b0;
    tick();

    // A: single strobe, full timeline; then a second strobe at minimum spacing.
    strobe();
    for (int k = 1; k <= 9; k++) begin
      check("A_busy", busy0, (k <= 8) ? 1 : 0);
      check("A_wr_en", wr_en0, (k == 1) ? 1 : 0);
      if (k == 1) check("A_wr_addr", wa0, 0);
      check("A_rd_valid", rv0, (k >= 2 && k <= 5) ? 1 : 0);
      if (k >= 2 && k <= 5) begin
        check("A_rd_addr", ra0, ra4[k - 2]);
        check("A_coef_addr", ca0, k - 2);
      end
      check("A_acc_en", en0, (k >= 4 && k <= 7) ? 1 : 0);
      check("A_acc_clr", clr0, (k == 4) ? 1 : 0);
      check("A_out_valid", ovf0, (k == 8) ? 1 : 0);
      if (k >= 2 && k <= 6) check("A5_rd_addr", ra1, ra5[k - 2]);
      check("A5_out_valid", ovf1, 0);
      if (k < 9) tick();
    end
    strobe();
    check("A5_out_valid_t10", ovf1, 1);
    check("A5_overrun", ovr1, 1);
    check("A2_wr_addr", wa0, 1);
    for (int k = 2; k <= 5; k++) begin
      tick();
      check("A2_rd_addr", ra0, ra4b[k - 2]);
      check("A2_overrun", ovr0, 0);
    end
    repeat (8) tick();

    // C: strobe during MAC and during DONE are ignored; overrun sticks.
    do_reset();
    strobe();
    repeat (4) tick();
    check("C_overrun_before", ovr0, 0);
    sam_clk_en = 1'b1;
    tick();
    sam_clk_en = 1'b0;
    check("C_overrun_set", ovr0, 1);
    tick();
    tick();
    check("C_out_valid_t8", ovf0, 1);
    sam_clk_en = 1'b1;
    tick();
    sam_clk_en = 1'b0;
    check("C_done_strobe_ignored_wr", wr_en0, 0);
    check("C_done_strobe_ignored_busy", busy0, 0);
    repeat (10) tick();
    check("C_overrun_sticky", ovr0, 1);

    // B: five strobes spaced 12 cycles; write pointer wraps.
    do_reset();
    for (int s = 0; s < 5; s++) begin
      strobe();
      check("B_wr_addr", wa0, wb[s]);
      check("B5_wr_addr", wa1, s);
      if (s == 4) begin
        for (int k = 2; k <= 5; k++) begin
          tick();
          check("B_fifth_rd_addr", ra0, ra4[k - 2]);
        end
      end else begin
        repeat (11) tick();
      end
    end
    repeat (12) tick();
    check("B_overrun", ovr0, 0);

    // D: reset mid-operation aborts everything.
    do_reset();
    strobe();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 4; k <= 13; k++) begin
      check("D_quiet", {busy0, wr_en0, rv0, en0, clr0, ovf0, busy1, rv1, en1, ovf1}, 0);
      tick();
    end
    strobe();
    check("D_wr_addr_after_reset", wa0, 0);
    check("D5_wr_addr_after_reset", wa1, 0);
    repeat (16) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
